// File: rtl/mb_rtu_rx.sv
// Modbus RTU request receiver: parses function 0x03/0x10 requests, checks CRC-16 and inter-frame timing.
// Optional build macro MB_RX_BROADCAST_EN accepts address 0x00 for function 0x10 and adds the bcast output.
module mb_rtu_rx #(
   parameter logic [7:0] SLAVE_ID = 8'h01,
   parameter int         T35_CLKS = 200000,
   parameter int         MAX_REGS = 123
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        busy,
   output logic        wr_data_valid,
   output logic [7:0]  wr_data,
   output logic [7:0]  wr_data_idx,
   output logic        frame_valid,
   output logic [7:0]  mb_fun,
   output logic [15:0] mb_addr,
   output logic [15:0] mb_num,
   output logic        frame_err,
`ifdef MB_RX_BROADCAST_EN
   output logic        bcast,
`endif
   output logic [2:0]  err_code
);

   localparam int GW = $clog2(T35_CLKS + 1);

   localparam logic [2:0] ERR_CRC     = 3'd1;
   localparam logic [2:0] ERR_FUN     = 3'd2;
   localparam logic [2:0] ERR_LEN     = 3'd3;
   localparam logic [2:0] ERR_TIMEOUT = 3'd4;
   localparam logic [2:0] ERR_EXTRA   = 3'd5;

   typedef enum logic [3:0] {
      IDLE, FUN, FIELDS, BYTECNT, DATA, CRC, ERR_WAIT, DISCARD, WAIT_GAP
   } state_t;

   state_t        state, state_next;
   logic [GW-1:0] gap_cnt;
   logic          gap_evt;
   logic [15:0]   crc, crc_base, crc_next;
   logic [31:0]   fields;
   logic [15:0]   qty_next;
   logic [7:0]    fun_r;
   logic [1:0]    field_cnt;
   logic [7:0]    byte_cnt;
   logic [7:0]    data_idx;
   logic          crc_cnt;
   logic          bcast_r;
   logic          bcast_hit;
   logic          err_set, ok_set, wr_set;
   logic [2:0]    err_next;

   // Bitwise reflected CRC-16 (poly 0xA001) over one byte.
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      r = c ^ {8'h00, b};
      for (int i = 0; i < 8; i++)
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

`ifdef MB_RX_BROADCAST_EN
   assign bcast_hit = (rx_data == 8'h00);
`else
   assign bcast_hit = 1'b0;
   assign bcast_r   = 1'b0;
`endif

   assign gap_evt  = (gap_cnt == GW'(T35_CLKS));
   assign crc_base = (state == IDLE) ? 16'hFFFF : crc;
   assign crc_next = crc_byte(crc_base, rx_data);
   assign qty_next = {fields[7:0], rx_data};
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      err_set    = 1'b0;
      err_next   = 3'd0;
      ok_set     = 1'b0;
      wr_set     = 1'b0;
      case (state)
         IDLE:
            if (rx_valid)
               state_next = (rx_data == SLAVE_ID || bcast_hit) ? FUN : DISCARD;
         FUN:
            if (rx_valid) begin
               if ((rx_data == 8'h03 && !bcast_r) || rx_data == 8'h10) begin
                  state_next = FIELDS;
               end else begin
                  state_next = ERR_WAIT;
                  err_set    = 1'b1;
                  err_next   = ERR_FUN;
               end
            end
         FIELDS:
            if (rx_valid && field_cnt == 2'd3) begin
               if (qty_next == 16'd0 || qty_next > 16'(MAX_REGS)) begin
                  state_next = ERR_WAIT;
                  err_set    = 1'b1;
                  err_next   = ERR_LEN;
               end else begin
                  state_next = (fun_r == 8'h10) ? BYTECNT : CRC;
               end
            end
         BYTECNT:
            if (rx_valid) begin
               if (rx_data == {fields[6:0], 1'b0}) begin
                  state_next = DATA;
               end else begin
                  state_next = ERR_WAIT;
                  err_set    = 1'b1;
                  err_next   = ERR_LEN;
               end
            end
         DATA:
            if (rx_valid) begin
               wr_set = 1'b1;
               if (data_idx == byte_cnt - 8'd1) state_next = CRC;
            end
         CRC:
            if (rx_valid && crc_cnt) begin
               state_next = WAIT_GAP;
               if (crc_next == 16'h0000) begin
                  ok_set = 1'b1;
               end else begin
                  err_set  = 1'b1;
                  err_next = ERR_CRC;
               end
            end
         ERR_WAIT, DISCARD:
            if (gap_evt) state_next = IDLE;
         WAIT_GAP:
            if (gap_evt) begin
               state_next = IDLE;
            end else if (rx_valid) begin
               err_set  = 1'b1;
               err_next = ERR_EXTRA;
            end
         default: state_next = IDLE;
      endcase
      // A byte in the same cycle as the gap keeps the frame alive; only true silence times out.
      if ((state == FUN || state == FIELDS || state == BYTECNT || state == DATA || state == CRC)
          && gap_evt && !rx_valid) begin
         state_next = IDLE;
         err_set    = 1'b1;
         err_next   = ERR_TIMEOUT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt       <= '0;
         crc           <= 16'hFFFF;
         fields        <= '0;
         fun_r         <= '0;
         field_cnt     <= '0;
         byte_cnt      <= '0;
         data_idx      <= '0;
         crc_cnt       <= 1'b0;
         wr_data_valid <= 1'b0;
         wr_data       <= '0;
         wr_data_idx   <= '0;
         frame_valid   <= 1'b0;
         mb_fun        <= '0;
         mb_addr       <= '0;
         mb_num        <= '0;
         frame_err     <= 1'b0;
         err_code      <= '0;
      end else begin
         if (rx_valid)                    gap_cnt <= '0;
         else if (!gap_evt)               gap_cnt <= gap_cnt + GW'(1);

         if (rx_valid) begin
            case (state)
               IDLE: begin
                  crc       <= crc_next;
                  field_cnt <= '0;
                  data_idx  <= '0;
                  crc_cnt   <= 1'b0;
               end
               FUN: begin
                  crc   <= crc_next;
                  fun_r <= rx_data;
               end
               FIELDS: begin
                  crc       <= crc_next;
                  fields    <= {fields[23:0], rx_data};
                  field_cnt <= field_cnt + 2'd1;
               end
               BYTECNT: begin
                  crc      <= crc_next;
                  byte_cnt <= rx_data;
               end
               DATA: begin
                  crc      <= crc_next;
                  data_idx <= data_idx + 8'd1;
               end
               CRC: begin
                  crc     <= crc_next;
                  crc_cnt <= 1'b1;
               end
               default: ;
            endcase
         end

         wr_data_valid <= wr_set;
         if (wr_set) begin
            wr_data     <= rx_data;
            wr_data_idx <= data_idx;
         end
         frame_valid <= ok_set;
         if (ok_set) begin
            mb_fun  <= fun_r;
            mb_addr <= fields[31:16];
            mb_num  <= fields[15:0];
         end
         frame_err <= err_set;
         if (err_set) err_code <= err_next;
      end
   end

`ifdef MB_RX_BROADCAST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcast_r <= 1'b0;
         bcast   <= 1'b0;
      end else begin
         if (rx_valid && state == IDLE) bcast_r <= bcast_hit;
         if (ok_set)                    bcast   <= bcast_r;
      end
   end
`endif

endmodule

// File: tb/tb_mb_rtu_rx.sv
// Directed self-checking bench for mb_rtu_rx with a shortened 3.5-character gap.
module tb_mb_rtu_rx;

   localparam int T35 = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        busy;
   logic        wr_data_valid;
   logic [7:0]  wr_data;
   logic [7:0]  wr_data_idx;
   logic        frame_valid;
   logic [7:0]  mb_fun;
   logic [15:0] mb_addr;
   logic [15:0] mb_num;
   logic        frame_err;
   logic [2:0]  err_code;
`ifdef MB_RX_BROADCAST_EN
   logic        bcast;
`endif

   mb_rtu_rx #(.SLAVE_ID(8'h01), .T35_CLKS(T35), .MAX_REGS(123)) dut (
      .clk(clk),
      .rst(rst),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .busy(busy),
      .wr_data_valid(wr_data_valid),
      .wr_data(wr_data),
      .wr_data_idx(wr_data_idx),
      .frame_valid(frame_valid),
      .mb_fun(mb_fun),
      .mb_addr(mb_addr),
      .mb_num(mb_num),
      .frame_err(frame_err),
`ifdef MB_RX_BROADCAST_EN
      .bcast(bcast),
`endif
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   int          tests_run = 0;
   int          tests_failed = 0;
   int          fv_cnt = 0;
   int          fe_cnt = 0;
   int          wr_cnt = 0;
   logic [7:0]  wr_bytes [0:15];
   logic [7:0]  wr_idx   [0:15];
   logic [7:0]  frame    [0:15];
   int          frame_len = 0;

   // Pulse counters and payload capture, sampled before the edge updates the outputs.
   always @(posedge clk) begin
      if (frame_valid) fv_cnt++;
      if (frame_err)   fe_cnt++;
      if (wr_data_valid && wr_cnt < 16) begin
         wr_bytes[wr_cnt] = wr_data;
         wr_idx[wr_cnt]   = wr_data_idx;
         wr_cnt++;
      end
   end

   function automatic logic [15:0] model_crc(input int n);
      logic [15:0] c;
      c = 16'hFFFF;
      for (int i = 0; i < n; i++) begin
         c = c ^ {8'h00, frame[i]};
         for (int b = 0; b < 8; b++)
            c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic set_frame(input logic [127:0] v, input int n);
      for (int i = 0; i < n; i++) frame[i] = v[8*(n-1-i) +: 8];
      frame_len = n;
   endtask

   task automatic append_crc();
      logic [15:0] c;
      c = model_crc(frame_len);
      frame[frame_len]     = c[7:0];
      frame[frame_len + 1] = c[15:8];
      frame_len += 2;
   endtask

   // Sends the frame back-to-back; returns on the falling edge after the last byte was sampled.
   task automatic apply_stimulus();
      for (int i = 0; i < frame_len; i++) begin
         rx_valid = 1'b1;
         rx_data  = frame[i];
         @(negedge clk);
      end
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] exp_payload;
      logic        found;
      exp_payload = 32'h000A_0102;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      idle(3);
      check_output("reset_flags", {25'd0, busy, frame_valid, frame_err, wr_data_valid, err_code}, 32'd0);
      check_output("reset_fun_addr", {8'd0, mb_fun, mb_addr}, 32'd0);
      check_output("reset_num_wr", {mb_num, wr_data, wr_data_idx}, 32'd0);
      rst = 1'b0;
      idle(4);

      // Read request with the known-good CRC C5 CD.
      set_frame(64'h0103_0000_000A_C5CD, 8);
      apply_stimulus();
      check_output("read_fv_latency", {31'd0, frame_valid}, 32'd1);
      check_output("read_fun", {24'd0, mb_fun}, 32'h03);
      check_output("read_addr", {16'd0, mb_addr}, 32'h0000);
      check_output("read_num", {16'd0, mb_num}, 32'h000A);
      check_output("read_busy_wait_gap", {31'd0, busy}, 32'd1);
      idle(1);
      check_output("read_fv_one_cycle", {31'd0, frame_valid}, 32'd0);
      idle(T35 + 8);
      check_output("read_busy_after_gap", {31'd0, busy}, 32'd0);
      check_output("read_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd1, 16'd0});

      // Write multiple registers with a payload of four bytes.
      set_frame(88'h0110_0001_0002_04_000A_0102, 11);
      append_crc();
      wr_cnt = 0;
      apply_stimulus();
      check_output("write_fv_latency", {31'd0, frame_valid}, 32'd1);
      check_output("write_fun", {24'd0, mb_fun}, 32'h10);
      check_output("write_addr", {16'd0, mb_addr}, 32'h0001);
      check_output("write_num", {16'd0, mb_num}, 32'h0002);
      idle(T35 + 8);
      check_output("write_strobe_count", wr_cnt, 32'd4);
      for (int i = 0; i < 4; i++) begin
         check_output($sformatf("write_byte%0d", i), {24'd0, wr_bytes[i]}, {24'd0, exp_payload[8*(3-i) +: 8]});
         check_output($sformatf("write_idx%0d", i), {24'd0, wr_idx[i]}, i);
      end
      check_output("write_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd2, 16'd0});

      // Corrupted final CRC byte, then a good frame after the gap.
      set_frame(64'h0103_0000_000A_C5CC, 8);
      apply_stimulus();
      check_output("crc_err_pulse", {31'd0, frame_err}, 32'd1);
      check_output("crc_err_code", {29'd0, err_code}, 32'd1);
      check_output("crc_no_fv", {31'd0, frame_valid}, 32'd0);
      idle(T35 + 8);
      set_frame(64'h0103_0000_000A_C5CD, 8);
      apply_stimulus();
      check_output("recover_fv", {31'd0, frame_valid}, 32'd1);
      idle(T35 + 8);
      check_output("crc_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd3, 16'd1});

      // Frame for another station is dropped silently.
      set_frame(64'h0203_0000_000A_0000, 8);
      apply_stimulus();
      check_output("other_addr_busy", {31'd0, busy}, 32'd1);
      idle(T35 + 8);
      check_output("other_addr_idle", {31'd0, busy}, 32'd0);
      check_output("other_addr_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd3, 16'd1});

      // Unsupported function code.
      set_frame(48'h0105_0000_FF00, 6);
      append_crc();
      apply_stimulus();
      idle(T35 + 8);
      check_output("bad_fun_code", {29'd0, err_code}, 32'd2);
      check_output("bad_fun_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd3, 16'd2});

      // Truncated frame times out.
      set_frame(40'h0103_0000_00, 5);
      apply_stimulus();
      found = 1'b0;
      for (int i = 0; i < 3 * T35 && !found; i++) begin
         @(negedge clk);
         if (frame_err) found = 1'b1;
      end
      check_output("timeout_seen", {31'd0, found}, 32'd1);
      check_output("timeout_code", {29'd0, err_code}, 32'd4);
      check_output("timeout_busy", {31'd0, busy}, 32'd0);
      idle(4);
      check_output("timeout_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd3, 16'd3});

      // Reset in the middle of a frame, then a fresh request.
      set_frame(24'h010300, 3);
      apply_stimulus();
      rst = 1'b1;
      #1;
      check_output("midrst_flags", {25'd0, busy, frame_valid, frame_err, wr_data_valid, err_code}, 32'd0);
      check_output("midrst_fun_num", {8'd0, mb_fun, mb_num}, 32'd0);
      idle(2);
      rst = 1'b0;
      idle(4);
      set_frame(64'h0103_0000_000A_C5CD, 8);
      apply_stimulus();
      check_output("post_rst_fv", {31'd0, frame_valid}, 32'd1);
      check_output("post_rst_num", {16'd0, mb_num}, 32'h000A);
      idle(T35 + 8);
      check_output("post_rst_counts", {fv_cnt[15:0], fe_cnt[15:0]}, {16'd4, 16'd3});

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mb_rtu_rx.md
Name: mb_rtu_rx

Overview:
Modbus RTU request receiver. It is the inbound counterpart of the RTU response transmitter. It takes a byte stream from the UART receiver and parses slave-address, function, start-address and quantity fields. For function 0x10 it also parses the byte count and write payload. It checks the CRC-16 and frame timing, then reports a validated request to the register-bank and transmit logic.

Parameters:
SLAVE_ID, 8'h01, station address this block answers to.
T35_CLKS, 200000, clocks of line idle equal to 3.5 characters (50 MHz, 9600 baud).
MAX_REGS, 123, maximum register quantity accepted for functions 0x03 and 0x10.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
rx_valid  in  1  one-cycle strobe; rx_data holds a received byte.
rx_data  in  8  received byte.
busy  out  1  high while a frame is being parsed or discarded.
wr_data_valid  out  1  one-cycle strobe per 0x10 payload byte.
wr_data  out  8  payload byte.
wr_data_idx  out  8  payload byte index, 0-based.
frame_valid  out  1  one-cycle pulse: request accepted.
mb_fun  out  8  function code; held until the next frame_valid.
mb_addr  out  16  start register address; held.
mb_num  out  16  register quantity; held.
frame_err  out  1  one-cycle pulse: frame rejected.
err_code  out  3  cause, valid with frame_err; held.

Behaviour:
- Reset values: every output 0; state is IDLE; CRC register 16'hFFFF; gap counter 0.
- CRC:
  - Modbus CRC-16: reflected polynomial 16'hA001, initial value 16'hFFFF, updated one byte per rx_valid.
  - Every frame byte feeds the CRC, including the two CRC bytes (low byte first).
  - The frame passes when the residue is 16'h0000.
- Gap counter:
  - Clears on rx_valid; otherwise increments, saturating at T35_CLKS.
  - Reaching T35_CLKS is the gap event.
- States and transitions:
  - IDLE: the first rx_valid loads the CRC with the init value plus that byte.
    - Byte equals SLAVE_ID: go to FUN.
    - Otherwise: go to DISCARD.
  - FUN: byte 0x03 or 0x10 goes to FIELDS. Any other byte goes to ERR_WAIT with err_code 2 (BAD_FUN).
  - FIELDS: four bytes, big-endian, into the address then the quantity.
    - After the 4th byte, a quantity of 0 or greater than MAX_REGS gives err_code 3 (BAD_LEN).
    - Otherwise fun 0x10 goes to BYTECNT and fun 0x03 goes to CRC.
  - BYTECNT: the byte must equal 2*quantity (8-bit compare), else err_code 3.
    - On a match, go to DATA.
  - DATA: each byte raises wr_data_valid with wr_data and wr_data_idx in the next cycle.
    - After byte count bytes, go to CRC.
  - CRC: two bytes. In the cycle after the 2nd byte:
    - Residue 0: frame_valid pulses, mb_fun/mb_addr/mb_num update in that same cycle, go to WAIT_GAP.
    - Else: frame_err with err_code 1 (CRC), go to WAIT_GAP.
  - ERR_WAIT: frame_err pulses once on entry. Incoming bytes are ignored. Gap event returns to IDLE.
  - DISCARD (address mismatch): silent, no error pulse. Gap event returns to IDLE.
  - WAIT_GAP:
    - A byte arriving here gives frame_err with err_code 5 (EXTRA) and stays in WAIT_GAP.
    - An earlier frame_valid is not retracted.
    - Gap event returns to IDLE.
- Timeout: a gap event in FUN/FIELDS/BYTECNT/DATA/CRC gives frame_err with err_code 4 (TIMEOUT) and returns directly to IDLE.
- Latency: frame_valid is asserted exactly 1 clk after the rx_valid of the final CRC byte.
- Payload commit: wr_data may be emitted before the CRC verdict. Consumers commit only on frame_valid and drop the payload on frame_err.
- busy is high in every state except IDLE.
- rst mid-frame: immediate return to reset values; no pulses are emitted.
- rx_valid in back-to-back cycles must be accepted without loss.

Optional Feature:
MB_RX_BROADCAST_EN
- Defined: address byte 8'h00 is accepted like SLAVE_ID, but only with function 0x10. It adds output bcast (1 bit, reset 0), registered with frame_valid, so the transmit path suppresses its response.
- Broadcast with function 0x03 is treated as BAD_FUN.
- Undefined: address 0 goes to DISCARD and no bcast port exists.

Test Plan:
- Read request: bytes 01 03 00 00 00 0A C5 CD, 1-clk spacing. Expect frame_valid 1 clk after CD, mb_fun=03, mb_addr=0000, mb_num=000A, no frame_err.
- Write request: 01 10 00 01 00 02 04 00 0A 01 02 plus a bench-model CRC. Expect 4 wr_data_valid strobes (00,0A,01,02 at idx 0..3), then frame_valid with mb_addr=0001 and mb_num=0002.
- Corruption: same read frame with the last byte CC. Expect frame_err with err_code=1, no frame_valid; the next valid frame after T35_CLKS idle is accepted.
- Address and function filtering:
  - Frame addressed to 02: no pulses at all, busy low after the gap.
  - Function 05 to our address: frame_err with err_code=2.
- Timing: stop after 5 bytes and idle T35_CLKS. Expect frame_err with err_code=4, busy low, state IDLE.
- rst pulse mid-frame, then a fresh valid frame: outputs zero during reset, fresh frame accepted normally.
